// File: rtl/tmem_twiddle_reader_pkg.sv
// Shared definitions for the twiddle-memory read controller: memory geometry,
// FSM encoding, the skid-buffer entry layout and the twiddle address function.
package tmem_twiddle_reader_pkg;

    localparam int MAXL      = 5;
    localparam int ADDR_W    = 4;
    localparam int DATA_W    = 48;
    localparam int BLOCK_NUM = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [2:0]        stage;
        logic              last;
    } tw_entry_t;

    // Butterfly j of stage s uses twiddle W_N^((j mod 2^s) * N/2^(s+1)).
    function automatic logic [ADDR_W-1:0] tw_addr(input logic [ADDR_W-1:0] j,
                                                  input logic [2:0]        s);
        logic [ADDR_W-1:0] mask;
        logic [2:0]        sh;
        mask = ADDR_W'((32'd1 << s) - 32'd1);
        sh   = 3'(MAXL - 1) - s;
        return (j & mask) << sh;
    endfunction

endpackage

// File: rtl/tmem_skid_fifo.sv
// Two-entry FIFO of {data, stage, last} that absorbs the one-cycle SRAM read
// latency; the head entry is presented to the butterfly datapath.
module tmem_skid_fifo
    import tmem_twiddle_reader_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  tw_entry_t push_entry,
    input  logic      pop,
    output tw_entry_t head,
    output logic [1:0] count
);

    tw_entry_t  mem_q [2];
    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count_q  <= 2'd0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr] <= push_entry;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // An empty buffer presents zeros rather than a stale entry.
    assign head  = (count_q != 2'd0) ? mem_q[rd_ptr] : '0;
    assign count = count_q;

endmodule

// File: rtl/tmem_twiddle_reader.sv
// Streams the twiddle factors of every butterfly of every radix-2 stage from
// memory port 1 to the butterfly unit over a valid/ready interface.
module tmem_twiddle_reader
    import tmem_twiddle_reader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2:0]           cfg_log2n,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err,
    output logic [BLOCK_NUM-1:0] tm_csb,
    output logic                 tm_oeb,
    output logic                 tm_web,
    output logic [ADDR_W-1:0]    tm_a,
    input  logic [DATA_W-1:0]    tm_o,
    output logic [DATA_W-1:0]    tw_data,
    output logic [2:0]           tw_stage,
    output logic                 tw_last,
    output logic                 tw_valid,
    input  logic                 tw_ready
);

    // tw_valid/tw_ready: a word transfers in every cycle where both are high;
    // once tw_valid rises, it and the tw_* payload hold until that transfer.

    state_t            state, state_d;
    logic [2:0]        l_q, l_d;
    logic [2:0]        s_q, s_d;
    logic [ADDR_W-1:0] j_q, j_d;
    logic [ADDR_W-1:0] j_end;
    logic              inflight_q;
    logic [2:0]        inflight_stage_q;
    logic              inflight_last_q;
    logic              done_q;
    logic              cfg_err_q;
    logic              cfg_legal;
    logic              issue;
    logic              issue_last;
    logic              pop;
    logic              credit;
    logic [1:0]        used;
    logic [1:0]        count;
    tw_entry_t         head;
    tw_entry_t         push_entry;

    assign cfg_legal  = (cfg_log2n != 3'd0) && (cfg_log2n <= 3'(MAXL));
    assign j_end      = ADDR_W'((32'd1 << (l_q - 3'd1)) - 32'd1);
    assign issue_last = (s_q == l_q - 3'd1) && (j_q == j_end);
    assign pop        = tw_valid & tw_ready;

    // A slot freed by this cycle's pop is reusable immediately, which keeps
    // the stream bubble-free while the consumer is always ready.
    assign used   = count - {1'b0, pop} + {1'b0, inflight_q};
    assign credit = (used < 2'd2);

    always_comb begin
        state_d = state;
        l_d     = l_q;
        s_d     = s_q;
        j_d     = j_q;
        issue   = 1'b0;
        case (state)
            IDLE: begin
                if (start && cfg_legal) begin
                    l_d     = cfg_log2n;
                    s_d     = 3'd0;
                    j_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (credit) begin
                    issue = 1'b1;
                    if (j_q == j_end) begin
                        j_d = '0;
                        s_d = s_q + 3'd1;
                        if (issue_last) begin
                            state_d = DRAIN;
                        end
                    end else begin
                        j_d = j_q + ADDR_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (pop && head.last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            l_q              <= 3'd0;
            s_q              <= 3'd0;
            j_q              <= '0;
            inflight_q       <= 1'b0;
            inflight_stage_q <= 3'd0;
            inflight_last_q  <= 1'b0;
            done_q           <= 1'b0;
            cfg_err_q        <= 1'b0;
        end else begin
            state            <= state_d;
            l_q              <= l_d;
            s_q              <= s_d;
            j_q              <= j_d;
            inflight_q       <= issue;
            inflight_stage_q <= s_q;
            inflight_last_q  <= issue_last;
            done_q           <= (state == DRAIN) && pop && head.last;
            cfg_err_q        <= (state == IDLE) && start && !cfg_legal;
        end
    end

    assign push_entry = '{data: tm_o, stage: inflight_stage_q, last: inflight_last_q};

    tmem_skid_fifo u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (inflight_q),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (count)
    );

    assign tm_csb   = issue ? {BLOCK_NUM{1'b0}} : {BLOCK_NUM{1'b1}};
    assign tm_oeb   = ~issue;
    assign tm_web   = 1'b1;
    assign tm_a     = issue ? tw_addr(j_q, s_q) : '0;
    assign busy     = (state != IDLE);
    assign done     = done_q;
    assign cfg_err  = cfg_err_q;
    assign tw_valid = (count != 2'd0);
    assign tw_data  = head.data;
    assign tw_stage = head.stage;
    assign tw_last  = head.last;

endmodule

// File: tb/tb_tmem_twiddle_reader.sv
// Bench for tmem_twiddle_reader: address-echo memory model, table of passes,
// and hand-written reset / stall / start-while-busy sequences.
module tb_tmem_twiddle_reader;
  import tmem_twiddle_reader_pkg::*;

  localparam int W          = DATA_W + 4;
  localparam int MODE_READY = 0;
  localparam int MODE_RAND  = 1;
  localparam int MODE_HOLD  = 2;

  typedef struct {
    logic [2:0] log2n;
    int         mode;
    int         exp_count;
    bit         exp_err;
    bit         poke;
  } vec_t;

  // clock / reset / DUT
  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [2:0]           cfg_log2n = 3'd0;
  logic                 busy, done, cfg_err;
  logic [BLOCK_NUM-1:0] tm_csb;
  logic                 tm_oeb, tm_web;
  logic [ADDR_W-1:0]    tm_a;
  logic [DATA_W-1:0]    tm_o = '0;
  logic [DATA_W-1:0]    tw_data;
  logic [2:0]           tw_stage;
  logic                 tw_last, tw_valid;
  logic                 tw_ready = 1'b1;

  always #5 clk = ~clk;

  tmem_twiddle_reader dut (
    .clk(clk), .rst(rst), .start(start), .cfg_log2n(cfg_log2n),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .tm_csb(tm_csb), .tm_oeb(tm_oeb), .tm_web(tm_web), .tm_a(tm_a), .tm_o(tm_o),
    .tw_data(tw_data), .tw_stage(tw_stage), .tw_last(tw_last),
    .tw_valid(tw_valid), .tw_ready(tw_ready)
  );

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return {a, 28'hC0DE5A0, 12'h000, a};
  endfunction

  // address-echo memory: data appears the cycle after the address is sampled
  always @(posedge clk) begin
    if (tm_csb == '0 && !tm_oeb) tm_o <= mem_word(tm_a);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  int            n_checks = 0;
  int            n_err = 0;
  logic [W-1:0]  exp_q[$];
  int            issues_n = 0;
  int            hs_n = 0;
  int            done_n = 0;
  int            cfg_err_n = 0;
  int            first_hs_cyc = 0;
  int            last_hs_cyc = 0;
  bit            first_pending = 0;
  logic          prev_stall = 1'b0;
  logic [W-1:0]  prev_word = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] exp_word(input int addr, input int stage, input bit last);
    return {mem_word(ADDR_W'(addr)), 3'(stage), last};
  endfunction

  // monitor: handshakes against the expected queue, invariants every cycle
  always @(negedge clk) begin
    logic [W-1:0] word;
    logic [W-1:0] e;
    if (rst) begin
      issues_n   = 0;
      hs_n       = 0;
      prev_stall = 1'b0;
    end else begin
      word = {tw_data, tw_stage, tw_last};
      check("tm_web_high", 64'(tm_web), 64'd1);
      check("tm_oeb_vs_csb", 64'(tm_oeb), 64'(tm_csb[0]));
      if (tm_csb == '0) issues_n++;
      if (tw_valid && tw_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL extra_output: got 0x%0h expected no output (cycle %0d)", word, cyc);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("twiddle_%0d", hs_n), 64'(word), 64'(e));
        end
        if (first_pending) begin
          first_hs_cyc  = cyc;
          first_pending = 0;
        end
        if (tw_last) last_hs_cyc = cyc;
        hs_n++;
      end
      n_checks++;
      if (issues_n - hs_n > 2) begin
        n_err++;
        $display("FAIL outstanding: got %0d expected <=2 (cycle %0d)", issues_n - hs_n, cyc);
      end
      if (prev_stall) check("stall_hold", 64'({tw_valid, word}), 64'({1'b1, prev_word}));
      prev_stall = tw_valid && !tw_ready;
      prev_word  = word;
      if (done) begin
        done_n++;
        check("done_busy_low", 64'(busy), 64'd0);
        check("done_after_last", 64'(cyc), 64'(last_hs_cyc + 1));
      end
      if (cfg_err) cfg_err_n++;
    end
  end

  // driver: expected stream of a pass
  task automatic load_expect(input int l);
    int half;
    int a3[12];
    int st3[12];
    half = 1 << (l - 1);
    a3  = '{0, 0, 0, 0, 0, 8, 0, 8, 0, 4, 8, 12};
    st3 = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};
    if (l == 3) begin
      for (int k = 0; k < 12; k++) exp_q.push_back(exp_word(a3[k], st3[k], k == 11));
    end else begin
      for (int s = 0; s < l; s++)
        for (int j = 0; j < half; j++)
          exp_q.push_back(exp_word((j % (1 << s)) * (1 << (MAXL - 1 - s)), s,
                                   (s == l - 1) && (j == half - 1)));
    end
  endtask

  // driver: one pass, or one rejected start
  task automatic run_pass(input vec_t v);
    int  hs0, iss0, done0, err0, start_cyc;
    bit  got_done;
    got_done = 0;
    hs0   = hs_n;
    iss0  = issues_n;
    done0 = done_n;
    err0  = cfg_err_n;
    if (!v.exp_err) load_expect(int'(v.log2n));
    tw_ready      = (v.mode != MODE_HOLD);
    first_pending = 1;
    cfg_log2n     = v.log2n;
    start         = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    start_cyc = cyc;
    if (v.exp_err) begin
      check($sformatf("cfg_err_pulse_l%0d", v.log2n), 64'(cfg_err), 64'd1);
      check("cfg_err_busy", 64'(busy), 64'd0);
      repeat (3) begin
        @(posedge clk); #1;
        check("cfg_err_csb_idle", 64'(tm_csb == '1), 64'd1);
        check("cfg_err_stay_idle", 64'(busy), 64'd0);
      end
      check("cfg_err_count", 64'(cfg_err_n - err0), 64'd1);
      check("cfg_err_no_done", 64'(done_n - done0), 64'd0);
      first_pending = 0;
    end else begin
      check($sformatf("busy_after_start_l%0d", v.log2n), 64'(busy), 64'd1);
      check("no_cfg_err", 64'(cfg_err), 64'd0);
      for (int i = 0; i < 3000 && !got_done; i++) begin
        if (v.mode == MODE_RAND) tw_ready = 1'($urandom_range(0, 1));
        if (v.mode == MODE_HOLD && i == 20) begin
          check("hold_valid", 64'(tw_valid), 64'd1);
          check("hold_reads_issued", 64'(issues_n - iss0), 64'd2);
          check("hold_no_issue", 64'(tm_csb == '1), 64'd1);
          tw_ready = 1'b1;
        end
        if (v.poke) begin
          start     = (i == 5);
          cfg_log2n = (i == 5) ? 3'd0 : v.log2n;
        end
        @(posedge clk); #1;
        if (done) got_done = 1;
      end
      start    = 1'b0;
      tw_ready = 1'b1;
      check($sformatf("done_seen_l%0d", v.log2n), 64'(got_done), 64'd1);
      @(negedge clk); #1;
      check("pass_length", 64'(hs_n - hs0), 64'(v.exp_count));
      check("exp_q_drained", 64'(exp_q.size()), 64'd0);
      check("done_once", 64'(done_n - done0), 64'd1);
      check("no_cfg_err_in_pass", 64'(cfg_err_n - err0), 64'd0);
      if (v.mode == MODE_READY) begin
        check("first_valid_latency", 64'(first_hs_cyc - start_cyc), 64'd2);
        check("no_bubbles", 64'(last_hs_cyc - first_hs_cyc), 64'(v.exp_count - 1));
      end
      repeat (3) @(posedge clk);
      #1;
      check("idle_after_pass", 64'(busy), 64'd0);
      check("single_done_after_idle", 64'(done_n - done0), 64'd1);
    end
    exp_q.delete();
  endtask

  vec_t vecs[9];

  initial begin
    int d0;
    int hs0;
    vecs[0] = '{3'd5, MODE_READY, 80, 1'b0, 1'b0};
    vecs[1] = '{3'd3, MODE_READY, 12, 1'b0, 1'b0};
    vecs[2] = '{3'd1, MODE_READY,  1, 1'b0, 1'b0};
    vecs[3] = '{3'd2, MODE_READY,  4, 1'b0, 1'b0};
    vecs[4] = '{3'd4, MODE_RAND,  32, 1'b0, 1'b0};
    vecs[5] = '{3'd4, MODE_HOLD,  32, 1'b0, 1'b0};
    vecs[6] = '{3'd0, MODE_READY,  0, 1'b1, 1'b0};
    vecs[7] = '{3'd6, MODE_READY,  0, 1'b1, 1'b0};
    vecs[8] = '{3'd3, MODE_READY, 12, 1'b0, 1'b1};

    // reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tm_csb", 64'(tm_csb == '1), 64'd1);
    check("rst_tm_oeb", 64'(tm_oeb), 64'd1);
    check("rst_tm_a", 64'(tm_a), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_cfg_err", 64'(cfg_err), 64'd0);
    check("rst_tw_valid", 64'(tw_valid), 64'd0);
    check("rst_tw_payload", 64'({tw_data, tw_stage, tw_last}), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 9; k++) run_pass(vecs[k]);

    // reset in the middle of an L=5 pass
    hs0 = hs_n;
    load_expect(5);
    tw_ready  = 1'b1;
    cfg_log2n = 3'd5;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 200 && (hs_n - hs0) < 10; i++) begin
      @(posedge clk); #1;
    end
    check("mid_reset_reached_10", 64'(hs_n - hs0), 64'd10);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_reset_tw_valid", 64'(tw_valid), 64'd0);
    check("mid_reset_busy", 64'(busy), 64'd0);
    check("mid_reset_csb", 64'(tm_csb == '1), 64'd1);
    check("mid_reset_done", 64'(done), 64'd0);
    d0 = done_n;
    repeat (4) @(posedge clk);
    #1;
    check("mid_reset_no_done", 64'(done_n - d0), 64'd0);
    check("mid_reset_still_empty", 64'(tw_valid), 64'd0);
    run_pass(vecs[0]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
